// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the instruction fetch slice.
//   ADDR_W_DEF / DATA_W_DEF : default address and instruction widths
//   OPC_HALT                : major opcode that stops fetch when halt detection is built in
//   fetch_state_e           : fetch controller states; ST_HALT exists only when
//                             IFETCH_HALT_DETECT_EN is defined
package cpu_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [5:0] OPC_HALT = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DRAIN
`ifdef IFETCH_HALT_DETECT_EN
    , ST_HALT
`endif
  } fetch_state_e;

  function automatic logic is_halt(input logic [5:0] opc);
    return opc == OPC_HALT;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: request/grant instruction-memory bus.
//   IMemReq    : fetch request (master -> memory)
//   IMemAddr   : request address (master -> memory)
//   IMemGnt    : memory accepts the request this cycle (memory -> master)
//   IMemRValid : read data valid (memory -> master)
//   IMemRData  : read data (memory -> master)
// Modports: master = fetch unit, slave = instruction memory.
interface ifetch_unit_if import cpu_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              IMemReq;
  logic [ADDR_W-1:0] IMemAddr;
  logic              IMemGnt;
  logic              IMemRValid;
  logic [DATA_W-1:0] IMemRData;

  modport master (
    output IMemReq, IMemAddr,
    input  IMemGnt, IMemRValid, IMemRData
  );

  modport slave (
    input  IMemReq, IMemAddr,
    output IMemGnt, IMemRValid, IMemRData
  );

endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry synchronous FIFO of {instruction, PC} pairs.
//   CLK, Reset            : clock, synchronous active-high reset
//   push, push_inst/pc    : write one entry (caller guarantees space)
//   pop                   : drop the head entry (caller guarantees valid)
//   clear                 : empty the buffer; wins over push and pop
//   count                 : number of valid entries, 0..DEPTH
//   head_valid/inst/pc    : registered head entry, no write-through bypass
module ifetch_fifo #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_inst,
  input  logic [ADDR_W-1:0]          push_pc,
  input  logic                       pop,
  input  logic                       clear,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       head_valid,
  output logic [DATA_W-1:0]          head_inst,
  output logic [ADDR_W-1:0]          head_pc
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_inst [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Pointers are exactly log2(DEPTH) wide, so natural overflow is the modulo wrap.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_inst[wr_ptr] <= push_inst;
        mem_pc[wr_ptr]   <= push_pc;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_valid = (count != '0);
  assign head_inst  = mem_inst[rd_ptr];
  assign head_pc    = mem_pc[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage downstream of the PC register.
// Issues one memory request at a time for PCOut, pulses PCWre when the
// request is granted (or on a redirect), and buffers returned words with
// their PCs for decode. A redirect (Flush) empties the buffer and causes the
// data of an outstanding request to be discarded.
//   CLK, Reset      : clock, synchronous active-high reset
//   PCOut           : current fetch address from the PC register
//   PCWre           : PC load enable (advance on grant, or redirect on Flush)
//   Flush           : redirect; PC loads its target on this edge
//   imem            : instruction-memory bus (ifetch_unit_if.master)
//   InstValid/Inst/InstPC : buffer head toward decode
//   InstReady       : decode consumes the head when InstValid & InstReady
// Build option: define IFETCH_HALT_DETECT_EN to stop fetching after a word
// whose bits [31:26] equal OPC_HALT is buffered; only Reset leaves that state.
module ifetch_unit import cpu_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] PCOut,
  output logic              PCWre,
  input  logic              Flush,
  ifetch_unit_if.master     imem,
  output logic              InstValid,
  output logic [DATA_W-1:0] Inst,
  output logic [ADDR_W-1:0] InstPC,
  input  logic              InstReady
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state;
  logic [ADDR_W-1:0] pend_pc;
  logic [CNT_W-1:0]  count;
  logic              issue;
  logic              grant;
  logic              push;
  logic              pop;
  logic              halted;

`ifdef IFETCH_HALT_DETECT_EN
  assign halted = (state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

  // Only one request outstanding, and never more requests than free slots,
  // so returned data can always be pushed without back-pressure to memory.
  assign issue = (state == ST_IDLE) & ~Flush & ~Reset & (count < CNT_W'(DEPTH));
  assign grant = issue & imem.IMemGnt;

  assign imem.IMemReq  = issue;
  assign imem.IMemAddr = PCOut;

  assign PCWre = ~halted & (grant | Flush);

  assign push = (state == ST_WAIT) & imem.IMemRValid & ~Flush;
  assign pop  = InstValid & InstReady & ~Flush;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= ST_IDLE;
      pend_pc <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            pend_pc <= PCOut;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem.IMemRValid) begin
`ifdef IFETCH_HALT_DETECT_EN
            if (!Flush && is_halt(imem.IMemRData[DATA_W-1 -: 6])) begin
              state <= ST_HALT;
            end else begin
              state <= ST_IDLE;
            end
`else
            state <= ST_IDLE;
`endif
          end else if (Flush) begin
            // Request still in flight: its data belongs to the wrong path.
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (imem.IMemRValid) begin
            state <= ST_IDLE;
          end
        end
`ifdef IFETCH_HALT_DETECT_EN
        ST_HALT: begin
          state <= ST_HALT;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  ifetch_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .CLK        (CLK),
    .Reset      (Reset),
    .push       (push),
    .push_inst  (imem.IMemRData),
    .push_pc    (pend_pc),
    .pop        (pop),
    .clear      (Flush),
    .count      (count),
    .head_valid (InstValid),
    .head_inst  (Inst),
    .head_pc    (InstPC)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed scoreboard bench for ifetch_unit.
// A PC-register model and an instruction-memory model (latency 1 or 2) form
// the environment; the main process pushes expected PCs into exp_q and a
// monitor pops and compares whenever decode consumes an instruction.
module tb_ifetch_unit;
  import cpu_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          CLK;
  logic          Reset;
  logic          Flush;
  logic          InstReady;
  logic          PCWre;
  logic          InstValid;
  logic [AW-1:0] PCOut;
  logic [AW-1:0] InstPC;
  logic [DW-1:0] Inst;

  ifetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) imem ();

  ifetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .PCOut     (PCOut),
    .PCWre     (PCWre),
    .Flush     (Flush),
    .imem      (imem),
    .InstValid (InstValid),
    .Inst      (Inst),
    .InstPC    (InstPC),
    .InstReady (InstReady)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int            n_cmp;
  int            n_err;
  logic [AW-1:0] exp_q[$];
  int            pop_cyc[$];
  bit            rec_pops;
  int            cyc;
  int            pcwre_cnt;
  int            pcwre_base;
  int            lat;
  logic [AW-1:0] pc_target;

  logic          env_g, env_pw, env_fl, env_rs;
  logic [AW-1:0] env_a;
  logic          s1v, s2v;
  logic [AW-1:0] s1a, s2a;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hFC00_0000;
    return {8'hA5, a[23:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_pc(input logic [AW-1:0] t, input int budget);
    int k;
    k = 0;
    while (PCOut !== t && k < budget) begin
      tick();
      k++;
    end
    check("wait_pc", PCOut, t);
  endtask

  task automatic wait_empty(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || InstValid) && k < budget) begin
      tick();
      k++;
    end
    check("drain_queue", exp_q.size(), 0);
  endtask

  // PC register and instruction-memory model.
  initial begin
    PCOut = '0;
    imem.IMemRValid = 1'b0;
    imem.IMemRData  = '0;
    s1v = 1'b0; s2v = 1'b0; s1a = '0; s2a = '0;
    cyc = 0;
    pcwre_cnt = 0;
    forever begin
      @(negedge CLK);
      env_g  = imem.IMemReq & imem.IMemGnt;
      env_a  = imem.IMemAddr;
      env_pw = PCWre;
      env_fl = Flush;
      env_rs = Reset;
      if (PCWre) pcwre_cnt++;
      @(posedge CLK);
      cyc++;
      #1;
      if (env_rs) PCOut = '0;
      else if (env_pw) PCOut = env_fl ? pc_target : PCOut + 32'd4;
      s2v = s1v; s2a = s1a;
      s1v = env_g; s1a = env_a;
      if (lat == 1) begin
        imem.IMemRValid = s1v;
        imem.IMemRData  = mem_word(s1a);
      end else begin
        imem.IMemRValid = s2v;
        imem.IMemRData  = mem_word(s2a);
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [AW-1:0] e;
    forever begin
      @(negedge CLK);
      if (!Reset && InstValid && InstReady) begin
        if (rec_pops) pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pop: got pc 0x%0h inst 0x%0h, expected none", InstPC, Inst);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", InstPC, e);
          check("inst", Inst, mem_word(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; rec_pops = 0;
    lat = 1; pc_target = '0;
    Reset = 1'b1; Flush = 1'b0; InstReady = 1'b1;
    imem.IMemGnt = 1'b1;

    // Reset with grant asserted.
    repeat (2) begin
      @(negedge CLK);
      check("rst_req", imem.IMemReq, 0);
      check("rst_valid", InstValid, 0);
      check("rst_pcwre", PCWre, 0);
      check("rst_inst", Inst, 0);
      check("rst_instpc", InstPC, 0);
    end

    // Streaming with 1-cycle memory.
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    rec_pops = 1;
    pcwre_base = pcwre_cnt;
    @(posedge CLK); #2;
    Reset = 1'b0;
    @(negedge CLK);
    check("first_req", imem.IMemReq, 1);
    check("first_addr", imem.IMemAddr, 32'h0);
    wait_pc(32'hC, 40);
    imem.IMemGnt = 1'b0;
    wait_empty(40);
    rec_pops = 0;
    check("stream_pcwre_pulses", pcwre_cnt - pcwre_base, 3);
    check("stream_pop_count", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      check("stream_gap0", pop_cyc[1] - pop_cyc[0], 2);
      check("stream_gap1", pop_cyc[2] - pop_cyc[1], 2);
    end

`ifdef IFETCH_HALT_DETECT_EN
    // Halt opcode at 0x10 stops fetch until reset.
    tick();
    pc_target = 32'h200;
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    pcwre_base = pcwre_cnt;
    imem.IMemGnt = 1'b1;
    wait_pc(32'h14, 40);
    wait_empty(20);
    repeat (3) begin
      @(negedge CLK);
      check("halt_req", imem.IMemReq, 0);
      check("halt_pcwre", PCWre, 0);
    end
    tick();
    Flush = 1'b1;
    @(negedge CLK);
    check("halt_flush_pcwre", PCWre, 0);
    tick();
    Flush = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("halt_req2", imem.IMemReq, 0);
    end
    check("halt_pc_frozen", PCOut, 32'h14);
    check("halt_pcwre_pulses", pcwre_cnt - pcwre_base, 2);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge CLK);
    check("halt_reset_req", imem.IMemReq, 1);
    check("halt_reset_addr", imem.IMemAddr, 32'h0);
    check("halt_reset_valid", InstValid, 0);
`else
    // Back-pressure: exactly DEPTH words buffered, then no requests.
    tick();
    InstReady = 1'b0;
    imem.IMemGnt = 1'b1;
    wait_pc(32'h14, 40);
    tick();
    repeat (5) begin
      @(negedge CLK);
      check("full_req", imem.IMemReq, 0);
      check("full_valid", InstValid, 1);
      check("full_head_pc", InstPC, 32'hC);
    end
    check("full_pc", PCOut, 32'h14);
    tick();
    imem.IMemGnt = 1'b0;
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    InstReady = 1'b1;
    wait_empty(20);

    // Flush while a 2-cycle request is in flight, with a word buffered.
    tick();
    lat = 2;
    InstReady = 1'b0;
    pc_target = 32'h40;
    imem.IMemGnt = 1'b1;
    wait_pc(32'h1C, 40);
    Flush = 1'b1;
    @(negedge CLK);
    check("flush_no_req", imem.IMemReq, 0);
    tick();
    Flush = 1'b0;
    check("flush_target", PCOut, 32'h40);
    @(negedge CLK);
    check("flush_empty", InstValid, 0);
    tick();
    exp_q.push_back(32'h40);
    InstReady = 1'b1;
    wait_pc(32'h44, 40);
    imem.IMemGnt = 1'b0;
    wait_empty(40);
    repeat (4) tick();

    // Flush in the same cycle as read data.
    lat = 1;
    pc_target = 32'h80;
    pcwre_base = pcwre_cnt;
    imem.IMemGnt = 1'b1;
    wait_pc(32'h48, 20);
    Flush = 1'b1;
    @(negedge CLK);
    check("rv_flush_rvalid", imem.IMemRValid, 1);
    check("rv_flush_no_req", imem.IMemReq, 0);
    tick();
    Flush = 1'b0;
    @(negedge CLK);
    check("rv_flush_valid", InstValid, 0);
    check("rv_flush_req", imem.IMemReq, 1);
    check("rv_flush_addr", imem.IMemAddr, 32'h80);
    exp_q.push_back(32'h80);
    wait_pc(32'h84, 20);
    imem.IMemGnt = 1'b0;
    wait_empty(20);
    check("rv_flush_pcwre_pulses", pcwre_cnt - pcwre_base, 3);
`endif

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
